// File: rtl/imm_ext_pkg.sv
// ---------------------------------------------------------------------------
// imm_ext_pkg
// Shared definitions for the registered immediate-extension stage:
//   - extension mode encodings driven on i_mode
//   - handshake FSM state encoding (EMPTY / ONE / TWO items held)
// ---------------------------------------------------------------------------
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_ext_unit.sv
// ---------------------------------------------------------------------------
// imm_ext_unit
// Combinational immediate extender.
// Ports:
//   i_data  [IN_W-1:0]   raw immediate
//   i_mode  [1:0]        SIGN / ZERO / UPPER / BRANCH
//   o_data  [OUT_W-1:0]  extended word
// ---------------------------------------------------------------------------
module imm_ext_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  i_data,
    input  logic [1:0]       i_mode,
    output logic [OUT_W-1:0] o_data
);
    import imm_ext_pkg::*;

    logic [OUT_W-1:0] signExt;

    assign signExt = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};

    // Mode select; BRANCH drops the two top bits of the sign-extended word
    // so the word offset becomes a byte offset without an overflow flag.
    always_comb begin
        o_data = '0;
        case (i_mode)
            MODE_SIGN:   o_data = signExt;
            MODE_ZERO:   o_data = {{(OUT_W-IN_W){1'b0}}, i_data};
            MODE_UPPER:  o_data = {i_data, {(OUT_W-IN_W){1'b0}}};
            MODE_BRANCH: o_data = {signExt[OUT_W-3:0], 2'b00};
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
// Registered immediate-extension stage with valid/ready handshake and a
// 2-entry skid buffer so that o_ready can be a register while still
// sustaining one item per cycle.
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_valid / o_ready         upstream handshake (o_ready registered)
//   i_data, i_mode, i_tag     immediate, extension mode, sideband tag
//   o_valid / i_ready         downstream handshake
//   o_data, o_tag             extended result and its tag
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_data,
    input  logic [1:0]       i_mode,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic [TAG_W-1:0] o_tag
);
    import imm_ext_pkg::*;

    state_e           state_q, state_d;
    logic             ready_q;
    logic [OUT_W-1:0] mainData_q, skidData_q;
    logic [TAG_W-1:0] mainTag_q, skidTag_q;
    logic [OUT_W-1:0] extData;
    logic             accept, pop;
    logic             loadMain, loadSkid, mainFromSkid;

    imm_ext_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .i_data (i_data),
        .i_mode (i_mode),
        .o_data (extData)
    );

    assign o_valid = (state_q != ST_EMPTY);
    assign o_ready = ready_q;
    assign o_data  = mainData_q;
    assign o_tag   = mainTag_q;

    assign accept = i_valid & ready_q;
    assign pop    = o_valid & i_ready;

    // Next state and register load enables. The main register always holds
    // the oldest item; the skid register only fills when the main one is
    // occupied and not leaving this cycle.
    always_comb begin
        state_d      = state_q;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    loadMain = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !pop) begin
                    state_d  = ST_TWO;
                    loadSkid = 1'b1;
                end else if (accept && pop) begin
                    loadMain = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d      = ST_ONE;
                    mainFromSkid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, registered ready and data/tag storage. Ready looks at the next
    // state so upstream sees it drop in the same cycle the buffer fills.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_EMPTY;
            ready_q    <= 1'b1;
            mainData_q <= '0;
            mainTag_q  <= '0;
            skidData_q <= '0;
            skidTag_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
            if (loadMain) begin
                mainData_q <= extData;
                mainTag_q  <= i_tag;
            end else if (mainFromSkid) begin
                mainData_q <= skidData_q;
                mainTag_q  <= skidTag_q;
            end
            if (loadSkid) begin
                skidData_q <= extData;
                skidTag_q  <= i_tag;
            end
        end
    end

endmodule
